instr_loader: RTL

- Upstream boot-loader stage for the single-cycle MIPS core.
- Receives a byte stream from a host over a valid/ready handshake and assembles it into 32-bit instruction words.
- Writes those words into the instruction memory block's write port, and holds the core (cpu_hold) while the load is in progress.
- Verifies the stream with a length header and an XOR checksum. Reports the outcome on load_done / load_error.

---
 rtl/instr_loader_if.sv | 19 +
 rtl/instr_loader.sv | 133 +++++++++++++
 2 files changed

// File: rtl/instr_loader_if.sv
// Host byte-stream handshake for the boot loader.
// Host drives valid/byte, loader answers with ready.
interface instr_loader_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_byte,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_byte,
    output in_ready
  );
endinterface

// File: rtl/instr_loader.sv
// Boot loader: assembles host bytes into instruction words,
// writes instruction memory and holds the core until verified.
module instr_loader #(
  parameter int ADDR_W    = 14,
  parameter int DEPTH     = 16384,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  instr_loader_if.slave     host,
  output logic              im_wr_en,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  len_hi;
  logic [7:0]  chk;
  logic [15:0] len;
  logic [15:0] idx;
  logic [1:0]  bcnt;
  logic [23:0] sh;

  logic        fire;
  logic        go;
  logic [15:0] len_in;
  logic        len_bad;
  logic        last_byte;
  logic        last_word;

  assign host.in_ready = (state == LEN_HI) || (state == LEN_LO) ||
                         (state == DATA)   || (state == CHK);

  assign fire      = host.in_valid && host.in_ready;
  assign go        = start && ((state == IDLE) || (state == DONE) ||
                               (state == ERR));
  assign len_in    = {len_hi, host.in_byte};
  assign len_bad   = (|len_in[15:14]) ||
                     ({16'd0, len_in} > 32'(DEPTH - BASE_ADDR));
  assign last_byte = (bcnt == 2'd3);
  assign last_word = (idx == len - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE, ERR: if (go) state_nx = LEN_HI;
      LEN_HI: if (fire) state_nx = LEN_LO;
      LEN_LO: begin
        if (fire) begin
          if (len_bad)           state_nx = ERR;
          else if (len_in == '0) state_nx = CHK;
          else                   state_nx = DATA;
        end
      end
      DATA: if (fire && last_byte && last_word) state_nx = CHK;
      CHK: begin
        if (fire) state_nx = (host.in_byte == chk) ? DONE : ERR;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      im_wr_en   <= 1'b0;
      im_addr    <= '0;
      im_wr_data <= '0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      len_hi     <= '0;
      len        <= '0;
      chk        <= '0;
      idx        <= '0;
      bcnt       <= '0;
      sh         <= '0;
    end else begin
      im_wr_en <= 1'b0;
      if (go) begin
        cpu_hold   <= 1'b1;
        load_done  <= 1'b0;
        load_error <= 1'b0;
        chk        <= '0;
        idx        <= '0;
        bcnt       <= '0;
      end
      if (fire) begin
        unique case (state)
          LEN_HI: begin
            len_hi <= host.in_byte;
            chk    <= chk ^ host.in_byte;
          end
          LEN_LO: begin
            len <= len_in;
            chk <= chk ^ host.in_byte;
          end
          DATA: begin
            chk  <= chk ^ host.in_byte;
            bcnt <= bcnt + 2'd1;
            sh   <= {sh[15:0], host.in_byte};
            // word is registered here, strobe appears next cycle
            if (last_byte) begin
              im_wr_en   <= 1'b1;
              im_wr_data <= {sh, host.in_byte};
              im_addr    <= ADDR_W'(BASE_ADDR) + idx[ADDR_W-1:0];
              idx        <= idx + 16'd1;
            end
          end
          default: ;
        endcase
      end
      if (state == CHK && state_nx == DONE) begin
        cpu_hold  <= 1'b0;
        load_done <= 1'b1;
      end
      if (state != ERR && state_nx == ERR) load_error <= 1'b1;
    end
  end

endmodule
